// File: rtl/requant_gain_ctrl.sv
// Closed-loop requant gain / arm sequencer: per-spectrum overflow
// window, hysteretic gain steps, and re-arm after every gain change.
module requant_gain_ctrl #(
  parameter int GAIN_INIT      = 16,
  parameter int OVF_HI         = 16,
  parameter int UP_SPECTRA     = 8,
  parameter int SETTLE_SPECTRA = 4,
  parameter int CNT_W          = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             agc_en,
  input  logic [4:0]       manual_gain,
  input  logic             sync_in,
  input  logic             ovf_a,
  input  logic             ovf_b,
  output logic [4:0]       gain,
  output logic             arm,
  output logic             gain_changed,
  output logic             locked,
  output logic [CNT_W-1:0] ovf_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_MEAS   = 3'd3,
    S_ADJ    = 3'd4
  } st_e;

  localparam int ZR_W = $clog2(UP_SPECTRA + 2);
  localparam int ST_W = $clog2(SETTLE_SPECTRA + 2);
  localparam logic [4:0]       G_INIT = 5'(GAIN_INIT);
  localparam logic [CNT_W-1:0] HI     = CNT_W'(OVF_HI);
  localparam logic [ZR_W-1:0]  UP     = ZR_W'(UP_SPECTRA);
  localparam logic [ST_W-1:0]  SET_N  = ST_W'(SETTLE_SPECTRA);

  st_e              st_q, st_d;
  logic [4:0]       gain_q, gain_d;
  logic [4:0]       pend_q, pend_d;
  logic [ZR_W-1:0]  zr_q, zr_d, zr_nx;
  logic [ST_W-1:0]  set_q, set_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             arm_q, arm_d;
  logic             chg_q, chg_d;
  logic             lock_q, lock_d;

  logic [1:0]       inc;
  logic [CNT_W:0]   sum;
  logic             manual_req, agc_eval, over, zero;

  // Window accumulator runs in every state, saturating.
  assign inc = {1'b0, ovf_a} + {1'b0, ovf_b};
  assign sum = (CNT_W+1)'(win_q) + (CNT_W+1)'(inc);

  always_comb begin
    win_d = win_q;
    ovf_d = ovf_q;
    if (sync_in) begin
      ovf_d = win_q;
      win_d = CNT_W'(inc);
    end else if (sum[CNT_W]) begin
      win_d = '1;
    end else begin
      win_d = sum[CNT_W-1:0];
    end
  end

  assign manual_req = !agc_en && (manual_gain != gain_q);
  assign agc_eval   = agc_en && sync_in;
  assign over       = win_q > HI;
  assign zero       = win_q == '0;
  assign zr_nx      = zr_q + ZR_W'(1);

  always_comb begin
    st_d   = st_q;
    gain_d = gain_q;
    pend_d = pend_q;
    zr_d   = zr_q;
    set_d  = set_q;
    arm_d  = 1'b0;
    chg_d  = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        gain_d = agc_en ? G_INIT : manual_gain;
        zr_d   = '0;
        if (enable) st_d = S_WAIT;
      end
      S_WAIT: begin
        if (sync_in) begin
          arm_d = 1'b1;
          set_d = SET_N;
          st_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (set_q == '0) begin
          st_d = S_MEAS;
        end else if (sync_in) begin
          set_d = set_q - ST_W'(1);
          if (set_q == ST_W'(1)) st_d = S_MEAS;
        end
      end
      S_MEAS: begin
        unique case (1'b1)
          manual_req: begin
            pend_d = manual_gain;
            zr_d   = '0;
            st_d   = S_ADJ;
          end
          agc_eval && over: begin
            zr_d = '0;
            if (gain_q != 5'd0) begin
              pend_d = gain_q - 5'd1;
              st_d   = S_ADJ;
            end
          end
          agc_eval && zero: begin
            if (zr_nx == UP) begin
              zr_d = '0;
              if (gain_q != 5'd31) begin
                pend_d = gain_q + 5'd1;
                st_d   = S_ADJ;
              end
            end else begin
              zr_d = zr_nx;
            end
          end
          agc_eval && !over && !zero: zr_d = '0;
          default: ;
        endcase
      end
      S_ADJ: begin
        gain_d = pend_q;
        chg_d  = 1'b1;
        st_d   = S_WAIT;
      end
      default: st_d = S_IDLE;
    endcase
    // Disable wins over everything; gain holds until IDLE reloads it.
    if (!enable) begin
      st_d  = S_IDLE;
      arm_d = 1'b0;
      chg_d = 1'b0;
      if (st_q != S_IDLE) gain_d = gain_q;
    end
  end

  assign lock_d = (st_d == S_MEAS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= S_IDLE;
      gain_q <= G_INIT;
      pend_q <= G_INIT;
      zr_q   <= '0;
      set_q  <= '0;
      win_q  <= '0;
      ovf_q  <= '0;
      arm_q  <= 1'b0;
      chg_q  <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      gain_q <= gain_d;
      pend_q <= pend_d;
      zr_q   <= zr_d;
      set_q  <= set_d;
      win_q  <= win_d;
      ovf_q  <= ovf_d;
      arm_q  <= arm_d;
      chg_q  <= chg_d;
      lock_q <= lock_d;
    end
  end

  assign gain         = gain_q;
  assign arm          = arm_q;
  assign gain_changed = chg_q;
  assign locked       = lock_q;
  assign ovf_count    = ovf_q;
  assign state        = st_q;

endmodule

// File: doc/requant_gain_ctrl.md
Name: requant_gain_ctrl

Overview:
- Closed-loop gain and arm controller for the requantizer/packetizer post-processing chain.
- Counts requantizer overflows (ovf_a, ovf_b) per spectrum, adjusts the shared 5-bit requant gain with hysteresis, and sequences the arm pulse.
- Every gain change is followed by a re-arm on a spectrum boundary, so each packet stream starts cleanly at one gain.
- Sits between the control registers and the post-processing block's gain/arm inputs.

Parameters:
- GAIN_INIT, 16: gain after reset and in IDLE when agc_en=1.
- OVF_HI, 16: window overflow count above which gain decrements.
- UP_SPECTRA, 8: consecutive zero-overflow windows required before gain increments.
- SETTLE_SPECTRA, 4: spectra ignored after each arm.
- CNT_W, 12: overflow counter width (saturating).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- enable  in  1  run controller; 0 forces IDLE
- agc_en  in  1  1 = automatic gain, 0 = gain tracks manual_gain
- manual_gain  in  5  software gain
- sync_in  in  1  single-cycle spectrum-start pulse
- ovf_a  in  1  channel A requant overflow flag
- ovf_b  in  1  channel B requant overflow flag
- gain  out  5  gain to requantizers
- arm  out  1  single-cycle arm pulse to requantizers/packetizer
- gain_changed  out  1  single-cycle pulse when gain updates
- locked  out  1  high while in MEASURE
- ovf_count  out  CNT_W  overflow total of last completed window
- state  out  3  IDLE=0, WAIT_SYNC=1, SETTLE=2, MEASURE=3, ADJUST=4

Behaviour:
- Reset (rst=0, async):
  - gain=GAIN_INIT; arm, gain_changed, locked, ovf_count, state = 0.
  - Window counter, zero-run counter and settle counter cleared.
- Window counter (all states):
  - Each cycle adds ovf_a+ovf_b (0..2), saturating at 2^CNT_W-1.
  - On a sync_in cycle: ovf_count <= accumulated value excluding this cycle; counter <= this cycle's ovf_a+ovf_b.
- IDLE:
  - arm=0; gain <= (agc_en ? GAIN_INIT : manual_gain).
  - enable=1 -> WAIT_SYNC.
- WAIT_SYNC:
  - On sync_in: arm=1 in the next cycle (exactly one cycle); settle counter <= SETTLE_SPECTRA; -> SETTLE.
- SETTLE:
  - Decrement on each sync_in; on the sync where it reaches 0 -> MEASURE.
  - SETTLE_SPECTRA=0: enter MEASURE on the cycle after arm.
- MEASURE (locked=1):
  - Evaluated only on sync_in, using the just-latched window; that window lies wholly inside MEASURE.
  - agc_en=1 and count>OVF_HI and gain>0: pending gain-1, zero-run<=0, -> ADJUST.
  - agc_en=1 and count==0: zero-run+1. If zero-run reaches UP_SPECTRA and gain<31: pending gain+1, zero-run<=0, -> ADJUST.
  - Otherwise (0<count<=OVF_HI): zero-run<=0, stay.
  - Gain at 0 or 31 with a request beyond the bound: no change, stay in MEASURE, zero-run<=0.
  - agc_en=0 and manual_gain!=gain, checked every cycle with no sync needed: pending=manual_gain -> ADJUST.
- ADJUST (exactly 1 cycle):
  - gain <= pending; gain_changed=1; -> WAIT_SYNC (re-arm).
  - A sync_in during ADJUST latches the window but does not arm; arm waits for the next sync.
- Mode and enable:
  - agc_en toggling in any non-IDLE state takes effect at the next MEASURE evaluation.
  - enable=0 in any state: next cycle state=IDLE, arm=0, locked=0. A pending arm is cancelled. Gain stays until the IDLE rule applies next cycle.
- Latency: registered outputs.
  - sync_in at cycle t in WAIT_SYNC -> arm high at t+1.
  - Decision at sync t -> gain/gain_changed at t+2 (ADJUST at t+1, registered update).

Test Plan:
- Bring-up: rst low 3 cycles, then enable=1, agc_en=1, syncs every 64 cycles, no overflow -> gain=16, arm pulse 1 cycle after first sync, locked rises at 5th sync.
- Overflow decrement: locked, 20 ovf_a cycles in one window -> ovf_count=20, gain 16->15, gain_changed pulse, state 4->1, arm after next sync, locked again 4 syncs later.
- Dual flags and hysteresis: ovf_a=ovf_b=1 for 8 cycles -> count 16, no change. Then 8 clean windows -> gain+1 on the 8th sync.
- Bounds: gain forced to 0 via manual mode, agc on, heavy overflow -> gain stays 0, no gain_changed, locked stays 1.
- Manual mode: agc_en=0, manual_gain 16->9 mid-window -> ADJUST, gain=9 two cycles later, re-arm on next sync.
- Abort: enable=0 in SETTLE, then sync arrives; and rst pulsed low mid-ADJUST -> state=0, arm=0, gain=GAIN_INIT immediately (async).
